// File: rtl/synch_toggle_tracker_if.sv
// Interface bundling the monitored value and the tracker's acknowledge/status
// outputs. clk and reset_n stay outside as plain ports.
// Optional feature macro: SYNCH_OVERRUN_CNT_EN adds the overrun_cnt signal.
interface synch_toggle_tracker_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 32
);
  logic [DATA_W-1:0] toggle_var;
  logic              toggle_var_changed;
  logic [CNT_W-1:0]  add_one_var;
  logic [DATA_W-1:0] last_value;
  logic              busy;
  logic              test_done;
`ifdef SYNCH_OVERRUN_CNT_EN
  logic [15:0]       overrun_cnt;
`endif

  // Driver side: produces toggle_var, observes the tracker.
  modport master (
    output toggle_var,
    input  toggle_var_changed, add_one_var, last_value, busy, test_done
`ifdef SYNCH_OVERRUN_CNT_EN
    , input overrun_cnt
`endif
  );

  // Tracker side: observes toggle_var, produces acknowledge and status.
  modport slave (
    input  toggle_var,
    output toggle_var_changed, add_one_var, last_value, busy, test_done
`ifdef SYNCH_OVERRUN_CNT_EN
    , output overrun_cnt
`endif
  );
endinterface

// File: rtl/synch_toggle_tracker.sv
// Toggle tracker: detects every change of toggle_var, waits DELAY cycles,
// then flips toggle_var_changed, bumps add_one_var and publishes the captured
// value on last_value. Changes arriving while waiting coalesce to the latest
// value. After DONE_COUNT acknowledges the FSM parks in DONE with a sticky
// test_done until reset.
// Optional feature macro: SYNCH_OVERRUN_CNT_EN adds a saturating 16-bit count
// of coalesced changes (overrun_cnt).
module synch_toggle_tracker #(
  parameter int DATA_W     = 4,
  parameter int DELAY      = 3,
  parameter int DONE_COUNT = 10,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  synch_toggle_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Countdown only needs to hold DELAY; keep at least one bit for DELAY==0.
  localparam int                DCNT_W   = (DELAY < 1) ? 1 : $clog2(DELAY + 1);
  localparam logic [DCNT_W-1:0] DLY      = DCNT_W'(DELAY);
  localparam logic [DCNT_W-1:0] DCNT_ONE = DCNT_W'(1);
  localparam logic [CNT_W-1:0]  DONE_VAL = CNT_W'(DONE_COUNT);
  // With zero delay a detected change goes straight to the acknowledge state.
  localparam state_t            RELOAD   = (DELAY == 0) ? S_ACK : S_WAIT;

  state_t            state;
  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] cap;
  logic [DCNT_W-1:0] dcnt;
  logic              flip_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] last_q;
  logic              done_q;
  logic              chg;
  logic [CNT_W-1:0]  cnt_inc;

`ifdef SYNCH_OVERRUN_CNT_EN
  logic [15:0]       overrun_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  assign chg     = (bus.toggle_var != prev_q);
  assign cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Change detector, countdown and acknowledge FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      prev_q    <= '0;
      cap       <= '0;
      dcnt      <= '0;
      flip_q    <= 1'b0;
      cnt_q     <= '0;
      last_q    <= '0;
      done_q    <= 1'b0;
`ifdef SYNCH_OVERRUN_CNT_EN
      overrun_q <= '0;
`endif
    end else begin
      prev_q <= bus.toggle_var;
      case (state)
        S_IDLE: begin
          if (chg) begin
            cap   <= bus.toggle_var;
            dcnt  <= DLY;
            state <= RELOAD;
          end
        end
        S_WAIT: begin
          // A change mid-countdown replaces the captured value but keeps the
          // original deadline, so acks never arrive faster than DELAY+1.
          if (chg) begin
            cap       <= bus.toggle_var;
`ifdef SYNCH_OVERRUN_CNT_EN
            overrun_q <= sat_inc16(overrun_q);
`endif
          end
          if (dcnt == DCNT_ONE) begin
            dcnt  <= '0;
            state <= S_ACK;
          end else begin
            dcnt  <= dcnt - DCNT_ONE;
          end
        end
        S_ACK: begin
          flip_q <= ~flip_q;
          cnt_q  <= cnt_inc;
          last_q <= cap;
          if (cnt_inc == DONE_VAL) begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end else if (chg) begin
            cap   <= bus.toggle_var;
            dcnt  <= DLY;
            state <= RELOAD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.toggle_var_changed = flip_q;
  assign bus.add_one_var        = cnt_q;
  assign bus.last_value         = last_q;
  assign bus.busy               = (state != S_IDLE);
  assign bus.test_done          = done_q;
`ifdef SYNCH_OVERRUN_CNT_EN
  assign bus.overrun_cnt        = overrun_q;
`endif

endmodule

// File: tb/tb_synch_toggle_tracker.sv
// Directed bench for synch_toggle_tracker with DELAY=3, DONE_COUNT=10.
// Edge numbering: edge 1 is the first rising edge after reset_n is released.
module tb_synch_toggle_tracker;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  synch_toggle_tracker_if #(.DATA_W(4), .CNT_W(32)) bus ();

  synch_toggle_tracker #(
    .DATA_W(4),
    .DELAY(3),
    .DONE_COUNT(10),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Advance n rising edges, then step 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges with toggle_var=init; afterwards we sit just
  // past "edge 0".
  task automatic apply_reset(input logic [3:0] init);
    bus.toggle_var = init;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    apply_reset(4'd0);
    if (bus.toggle_var_changed !== 1'b0) begin errors++; $display("FAIL rst_flip: got %0b want 0", bus.toggle_var_changed); end
    checks++;
    if (bus.add_one_var !== 32'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", bus.add_one_var); end
    checks++;
    if (bus.last_value !== 4'd0) begin errors++; $display("FAIL rst_last: got %0d want 0", bus.last_value); end
    checks++;
    if (bus.busy !== 1'b0 || bus.test_done !== 1'b0) begin errors++; $display("FAIL rst_busy_done: got %0b%0b want 00", bus.busy, bus.test_done); end
    checks++;
    tick(20);
    if (bus.toggle_var_changed !== 1'b0 || bus.add_one_var !== 32'd0 || bus.busy !== 1'b0 ||
        bus.last_value !== 4'd0 || bus.test_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got flip=%0b cnt=%0d busy=%0b last=%0d done=%0b want all 0",
               bus.toggle_var_changed, bus.add_one_var, bus.busy, bus.last_value, bus.test_done);
    end
    checks++;
  endtask

  task automatic test_single_ack;
    apply_reset(4'd0);
    tick(9);
    bus.toggle_var = 4'd5;            // sampled at edge 10
    tick(1);
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise: got %0b want 1", bus.busy); end
    checks++;
    tick(3);                          // after edge 13
    if (bus.toggle_var_changed !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL single_early: got flip=%0b busy=%0b want flip=0 busy=1", bus.toggle_var_changed, bus.busy);
    end
    checks++;
    tick(1);                          // after edge 14
    if (bus.toggle_var_changed !== 1'b1) begin errors++; $display("FAIL single_flip: got %0b want 1", bus.toggle_var_changed); end
    checks++;
    if (bus.add_one_var !== 32'd1) begin errors++; $display("FAIL single_count: got %0d want 1", bus.add_one_var); end
    checks++;
    if (bus.last_value !== 4'd5) begin errors++; $display("FAIL single_last: got %0d want 5", bus.last_value); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %0b want 0", bus.busy); end
    checks++;
  endtask

  task automatic test_coalesce;
    apply_reset(4'd0);
    tick(9);
    bus.toggle_var = 4'd3;            // sampled at edge 10
    tick(2);
    bus.toggle_var = 4'd9;            // sampled at edge 12, in WAIT
    tick(2);                          // after edge 13
    if (bus.toggle_var_changed !== 1'b0) begin errors++; $display("FAIL coal_early: got %0b want 0", bus.toggle_var_changed); end
    checks++;
    tick(1);                          // after edge 14
    if (bus.toggle_var_changed !== 1'b1 || bus.last_value !== 4'd9 || bus.add_one_var !== 32'd1) begin
      errors++; $display("FAIL coal_ack: got flip=%0b last=%0d cnt=%0d want 1 9 1",
                         bus.toggle_var_changed, bus.last_value, bus.add_one_var);
    end
    checks++;
`ifdef SYNCH_OVERRUN_CNT_EN
    if (bus.overrun_cnt !== 16'd1) begin errors++; $display("FAIL coal_overrun: got %0d want 1", bus.overrun_cnt); end
    checks++;
`endif
    tick(6);                          // after edge 20, no second ack
    if (bus.toggle_var_changed !== 1'b1 || bus.add_one_var !== 32'd1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL coal_single: got flip=%0b cnt=%0d busy=%0b want 1 1 0",
                         bus.toggle_var_changed, bus.add_one_var, bus.busy);
    end
    checks++;
  endtask

  task automatic test_done_count;
    apply_reset(4'd0);
    tick(9);
    for (int i = 0; i < 10; i++) begin
      bus.toggle_var = 4'(i + 1);
      tick(8);
      if (i == 8) begin
        if (bus.test_done !== 1'b0 || bus.add_one_var !== 32'd9) begin
          errors++; $display("FAIL done_before: got done=%0b cnt=%0d want 0 9", bus.test_done, bus.add_one_var);
        end
        checks++;
      end
    end
    if (bus.test_done !== 1'b1) begin errors++; $display("FAIL done_flag: got %0b want 1", bus.test_done); end
    checks++;
    if (bus.add_one_var !== 32'd10 || bus.last_value !== 4'd10 || bus.toggle_var_changed !== 1'b0) begin
      errors++; $display("FAIL done_state: got cnt=%0d last=%0d flip=%0b want 10 10 0",
                         bus.add_one_var, bus.last_value, bus.toggle_var_changed);
    end
    checks++;
    bus.toggle_var = 4'd11;           // ignored in DONE
    tick(10);
    if (bus.add_one_var !== 32'd10 || bus.toggle_var_changed !== 1'b0 ||
        bus.last_value !== 4'd10 || bus.test_done !== 1'b1) begin
      errors++; $display("FAIL done_frozen: got cnt=%0d flip=%0b last=%0d done=%0b want 10 0 10 1",
                         bus.add_one_var, bus.toggle_var_changed, bus.last_value, bus.test_done);
    end
    checks++;
  endtask

  task automatic test_reset_mid_wait;
    int bad;
    apply_reset(4'd0);
    tick(9);
    bus.toggle_var = 4'd5;            // sampled at edge 10
    tick(2);                          // after edge 11, in WAIT
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %0b want 1", bus.busy); end
    checks++;
    reset_n = 1'b0;                   // asserted ahead of edge 12
    bus.toggle_var = 4'd0;
    #1;
    if (bus.busy !== 1'b0 || bus.toggle_var_changed !== 1'b0 || bus.add_one_var !== 32'd0) begin
      errors++; $display("FAIL midrst_async: got busy=%0b flip=%0b cnt=%0d want 0 0 0",
                         bus.busy, bus.toggle_var_changed, bus.add_one_var);
    end
    checks++;
    tick(3);                          // after edge 14
    reset_n = 1'b1;                   // first active edge is 15
    bad = 0;
    for (int e = 15; e <= 30; e++) begin
      tick(1);
      if (bus.toggle_var_changed !== 1'b0 || bus.add_one_var !== 32'd0 || bus.busy !== 1'b0) bad++;
    end
    if (bad !== 0) begin errors++; $display("FAIL midrst_no_ack: got %0d bad cycles want 0", bad); end
    checks++;
  endtask

  task automatic test_back_to_back;
    apply_reset(4'd0);
    tick(9);
    bus.toggle_var = 4'd5;            // sampled at edge 10
    tick(4);                          // after edge 13, state ACK
    bus.toggle_var = 4'd0;            // sampled on the ACK edge 14
    tick(1);
    if (bus.toggle_var_changed !== 1'b1 || bus.add_one_var !== 32'd1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL b2b_first: got flip=%0b cnt=%0d busy=%0b want 1 1 1",
                         bus.toggle_var_changed, bus.add_one_var, bus.busy);
    end
    checks++;
    tick(3);                          // after edge 17
    if (bus.toggle_var_changed !== 1'b1 || bus.add_one_var !== 32'd1) begin
      errors++; $display("FAIL b2b_early: got flip=%0b cnt=%0d want 1 1", bus.toggle_var_changed, bus.add_one_var);
    end
    checks++;
    tick(1);                          // after edge 18
    if (bus.toggle_var_changed !== 1'b0 || bus.add_one_var !== 32'd2 ||
        bus.last_value !== 4'd0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL b2b_second: got flip=%0b cnt=%0d last=%0d busy=%0b want 0 2 0 0",
                         bus.toggle_var_changed, bus.add_one_var, bus.last_value, bus.busy);
    end
    checks++;
  endtask

  task automatic test_first_edge;
    apply_reset(4'd7);                // non-zero value seen at edge 1
    tick(4);                          // after edge 4
    if (bus.toggle_var_changed !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL first_early: got flip=%0b busy=%0b want 0 1", bus.toggle_var_changed, bus.busy);
    end
    checks++;
    tick(1);                          // after edge 5
    if (bus.toggle_var_changed !== 1'b1 || bus.last_value !== 4'd7 || bus.add_one_var !== 32'd1) begin
      errors++; $display("FAIL first_ack: got flip=%0b last=%0d cnt=%0d want 1 7 1",
                         bus.toggle_var_changed, bus.last_value, bus.add_one_var);
    end
    checks++;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.toggle_var = 4'd0;
    test_reset();
    test_single_ack();
    test_coalesce();
    test_done_count();
    test_reset_mid_wait();
    test_back_to_back();
    test_first_edge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
